mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the single-port, byte-lane data RAM between the instruction-fetch requester (I, read-only) and the MEM-stage requester (D, read/write).
- Grants at most one access per cycle and drives the RAM control, address and write-data inputs combinationally from the grant.
- Registers the read data and returns it one cycle after the grant.
- Performs sub-word store lane steering and load extraction/extension for D, and traps misaligned D accesses.

Parameters:
- STARVE_LIMIT, 4, consecutive denied I-request cycles after which I wins over D; legal range 1..15.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- i_req  in  1  I fetch request, held until i_ack
- i_addr  in  32  I fetch address, word aligned; bits [1:0] ignored
- i_ack  out  1  I granted this cycle (combinational)
- i_rvalid  out  1  I read data valid (registered)
- i_rdata  out  32  I read word
- d_req  in  1  D request, held until d_ack
- d_we  in  1  1 = store, 0 = load
- d_size  in  2  00 byte, 01 half, 10 word, 11 reserved (treated as misaligned)
- d_signed  in  1  sign-extend sub-word loads
- d_addr  in  32  D byte address
- d_wdata  in  32  store data, right-justified
- d_ack  out  1  D accepted this cycle (combinational)
- d_rvalid  out  1  D load data valid (registered)
- d_rdata  out  32  extended load data
- d_err  out  1  misaligned/reserved-size pulse (registered)
- mem_read_en  out  1  RAM read enable
- mem_write_en  out  1  RAM write enable
- mem_write_sel  out  4  RAM byte-lane enables
- mem_addr  out  32  RAM address, bits [1:0] forced to 0
- mem_wdata  out  32  lane-steered store data
- mem_rdata  in  32  RAM combinational read data

Behaviour:
- Clock clk; reset rst, synchronous, active-high.
- Reset: i_rvalid, d_rvalid, d_err, i_rdata, d_rdata, starve counter and all pending-response flags clear to 0. While rst=1, no grant is issued: i_ack=0, d_ack=0, and all mem_* outputs are 0.
- A response pending at a reset edge is discarded; no rvalid follows reset release.

Arbitration (combinational, per cycle):
- grant_i = i_req & (~d_req | starve_cnt == STARVE_LIMIT); grant_d = d_req & ~grant_i.
- starve_cnt increments (saturating at STARVE_LIMIT) on each cycle with i_req=1 and grant_i=0.
- starve_cnt clears on grant_i or when i_req=0.
- i_ack = grant_i; d_ack = grant_d. A misaligned D request is still acked.

Lane rules (little-endian, lane n = mem bits [8n+7:8n], n = addr[1:0]):
- Byte: any address is legal. sel = 1<<addr[1:0]; wdata = {4{d_wdata[7:0]}}.
- Half: requires addr[0]=0. sel = 0011 when addr[1]=0, 1100 when addr[1]=1; wdata = {2{d_wdata[15:0]}}.
- Word: requires addr[1:0]=00. sel = 1111; wdata = d_wdata.

Memory drive:
- grant_i: read_en=1, write_en=0, sel=0000.
- grant_d aligned load: read_en=1, sel=0000.
- grant_d aligned store: write_en=1, sel per lane rules; read_en=0.
- grant_d misaligned: no read, no write.
- No grant: all mem_* outputs are 0.

Response (registered, latency 1):
- At the posedge ending a grant cycle, mem_rdata is captured.
- I read: i_rvalid=1 for exactly one cycle with i_rdata = the captured word.
- D aligned load: d_rvalid=1 for one cycle. Byte/half loads select the addressed lane, then sign-extend if d_signed=1, else zero-extend.
- D store: neither d_rvalid nor d_err is asserted.
- D misaligned: d_err=1 for one cycle, d_rvalid=0.
- Back-to-back grants produce back-to-back responses. The rdata registers hold their value when rvalid=0.
- Simultaneous i_req and d_req with starve_cnt < STARVE_LIMIT: D wins, starve_cnt increments.

Test Plan:
- Reset mid-op: I grant at cycle 0, rst=1 at cycle 1 -> i_rvalid stays 0 through reset; all outputs are 0 while rst=1.
- I fetch at 0x100 with RAM word 0x8C010004 -> i_ack in the request cycle; next cycle i_rvalid=1, i_rdata=0x8C010004.
- D store byte 0xA5 at 0x203 -> mem_write_sel=1000, mem_wdata=0xA5A5A5A5, mem_addr=0x200. Signed byte load at 0x203 then gives d_rdata=0xFFFFFFA5; unsigned gives 0x000000A5.
- D store half 0x8001 at 0x206 -> sel=1100. Signed half load at 0x206 gives 0xFFFF8001.
- D word load at 0x202 -> d_ack=1 and no mem access; next cycle d_err=1, d_rvalid=0. d_size=11 -> same result.
- i_req held with d_req held continuously, STARVE_LIMIT=4 -> D granted 4 cycles, I granted on the 5th, then D resumes; the pattern repeats every 5 cycles.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the I-fetch, D-access and RAM-side signals around the shared data RAM port.
// slave is the arbiter's view; master is the requesters-plus-RAM view.
interface mem_port_arbiter_if;
   logic        i_req;
   logic [31:0] i_addr;
   logic        i_ack;
   logic        i_rvalid;
   logic [31:0] i_rdata;

   logic        d_req;
   logic        d_we;
   logic [1:0]  d_size;
   logic        d_signed;
   logic [31:0] d_addr;
   logic [31:0] d_wdata;
   logic        d_ack;
   logic        d_rvalid;
   logic [31:0] d_rdata;
   logic        d_err;

   logic        mem_read_en;
   logic        mem_write_en;
   logic [3:0]  mem_write_sel;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;

   modport slave (
      input  i_req, i_addr, d_req, d_we, d_size, d_signed, d_addr, d_wdata, mem_rdata,
      output i_ack, i_rvalid, i_rdata, d_ack, d_rvalid, d_rdata, d_err,
             mem_read_en, mem_write_en, mem_write_sel, mem_addr, mem_wdata
   );

   modport master (
      output i_req, i_addr, d_req, d_we, d_size, d_signed, d_addr, d_wdata, mem_rdata,
      input  i_ack, i_rvalid, i_rdata, d_ack, d_rvalid, d_rdata, d_err,
             mem_read_en, mem_write_en, mem_write_sel, mem_addr, mem_wdata
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// Single-port data RAM arbiter: D has priority, I wins after STARVE_LIMIT denied cycles.
// Handles sub-word store steering, load extraction/extension and misalignment traps.
module mem_port_arbiter #(
   parameter int unsigned STARVE_LIMIT = 4
) (
   input logic              clk,
   input logic              rst,
   mem_port_arbiter_if.slave bus
);
   localparam int unsigned CNT_W = 4;
   localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

   logic [CNT_W-1:0] starve_cnt;
   logic             grant_i;
   logic             grant_d;
   logic             misaligned;
   logic [3:0]       store_sel;
   logic [31:0]      store_data;
   logic [7:0]       lane_b;
   logic [15:0]      lane_h;
   logic [31:0]      load_data;
   logic             d_load_ok;

   logic             i_rvalid_q;
   logic             d_rvalid_q;
   logic             d_err_q;
   logic [31:0]      i_rdata_q;
   logic [31:0]      d_rdata_q;

   // No grant while reset is held so the RAM is never touched during reset.
   always_comb begin
      grant_i   = ~rst & bus.i_req & (~bus.d_req | (starve_cnt == LIMIT));
      grant_d   = ~rst & bus.d_req & ~grant_i;
      d_load_ok = grant_d & ~misaligned & ~bus.d_we;
   end

   always_comb begin
      case (bus.d_size)
         2'b00:   misaligned = 1'b0;
         2'b01:   misaligned = bus.d_addr[0];
         2'b10:   misaligned = |bus.d_addr[1:0];
         default: misaligned = 1'b1;
      endcase
   end

   // Store lane steering: replicate the right-justified data across lanes.
   always_comb begin
      store_sel  = 4'b0000;
      store_data = bus.d_wdata;
      case (bus.d_size)
         2'b00: begin
            store_sel  = 4'b0001 << bus.d_addr[1:0];
            store_data = {4{bus.d_wdata[7:0]}};
         end
         2'b01: begin
            store_sel  = bus.d_addr[1] ? 4'b1100 : 4'b0011;
            store_data = {2{bus.d_wdata[15:0]}};
         end
         2'b10: store_sel = 4'b1111;
         default: ;
      endcase
   end

   // Load extraction from the addressed lane, then sign or zero extension.
   always_comb begin
      case (bus.d_addr[1:0])
         2'b00:   lane_b = bus.mem_rdata[7:0];
         2'b01:   lane_b = bus.mem_rdata[15:8];
         2'b10:   lane_b = bus.mem_rdata[23:16];
         default: lane_b = bus.mem_rdata[31:24];
      endcase
      lane_h = bus.d_addr[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
      case (bus.d_size)
         2'b00:   load_data = {{24{bus.d_signed & lane_b[7]}}, lane_b};
         2'b01:   load_data = {{16{bus.d_signed & lane_h[15]}}, lane_h};
         default: load_data = bus.mem_rdata;
      endcase
   end

   always_comb begin
      bus.mem_read_en   = 1'b0;
      bus.mem_write_en  = 1'b0;
      bus.mem_write_sel = 4'b0000;
      bus.mem_addr      = 32'h0;
      bus.mem_wdata     = 32'h0;
      if (grant_i) begin
         bus.mem_read_en = 1'b1;
         bus.mem_addr    = {bus.i_addr[31:2], 2'b00};
      end else if (grant_d && !misaligned) begin
         bus.mem_addr = {bus.d_addr[31:2], 2'b00};
         if (bus.d_we) begin
            bus.mem_write_en  = 1'b1;
            bus.mem_write_sel = store_sel;
            bus.mem_wdata     = store_data;
         end else begin
            bus.mem_read_en = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         i_rvalid_q <= 1'b0;
         d_rvalid_q <= 1'b0;
         d_err_q    <= 1'b0;
         i_rdata_q  <= 32'h0;
         d_rdata_q  <= 32'h0;
         starve_cnt <= '0;
      end else begin
         i_rvalid_q <= grant_i;
         d_rvalid_q <= d_load_ok;
         d_err_q    <= grant_d & misaligned;
         if (grant_i) i_rdata_q <= bus.mem_rdata;
         if (d_load_ok) d_rdata_q <= load_data;
         if (bus.i_req && !grant_i)
            starve_cnt <= (starve_cnt == LIMIT) ? starve_cnt : starve_cnt + CNT_W'(1);
         else
            starve_cnt <= '0;
      end
   end

   // Responses are masked while reset is asserted so a response in flight is never seen.
   always_comb begin
      bus.i_ack    = grant_i;
      bus.d_ack    = grant_d;
      bus.i_rvalid = i_rvalid_q & ~rst;
      bus.d_rvalid = d_rvalid_q & ~rst;
      bus.d_err    = d_err_q & ~rst;
      bus.i_rdata  = rst ? 32'h0 : i_rdata_q;
      bus.d_rdata  = rst ? 32'h0 : d_rdata_q;
   end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Vector-table bench for mem_port_arbiter with a behavioural RAM and a response scoreboard.
module tb_mem_port_arbiter;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   mem_port_arbiter_if bus();
   mem_port_arbiter #(.STARVE_LIMIT(4)) dut (.clk(clk), .rst(rst), .bus(bus));

   bit [31:0] ram [0:1023];
   assign bus.mem_rdata = ram[bus.mem_addr[11:2]];
   always @(posedge clk)
      if (bus.mem_write_en)
         for (int b = 0; b < 4; b++)
            if (bus.mem_write_sel[b]) ram[bus.mem_addr[11:2]][8*b +: 8] <= bus.mem_wdata[8*b +: 8];

   typedef struct {
      logic rst; logic ir; logic [31:0] ia;
      logic dr; logic dwe; logic [1:0] dsz; logic dsg; logic [31:0] da; logic [31:0] dwd;
      logic eia; logic eda; logic ern; logic ewn; logic [3:0] esel; logic [31:0] eaddr; logic [31:0] ewd;
      logic riv; logic [31:0] rid; logic rdv; logic [31:0] rdd; logic rer;
   } vec_t;

   typedef struct packed {
      logic iv; logic [31:0] id; logic dv; logic [31:0] dd; logic er;
   } resp_t;

   localparam int NV = 23;
   vec_t  vecs [NV];
   resp_t exp_q [$];
   int    tests = 0;
   int    fails = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h, want %h", name, act, exp);
      end
   endtask

   // Drive one cycle, check the previous cycle's response and this cycle's grant/RAM drive.
   task automatic step(input vec_t v);
      resp_t r;
      @(negedge clk);
      rst          = v.rst;
      bus.i_req    = v.ir;
      bus.i_addr   = v.ia;
      bus.d_req    = v.dr;
      bus.d_we     = v.dwe;
      bus.d_size   = v.dsz;
      bus.d_signed = v.dsg;
      bus.d_addr   = v.da;
      bus.d_wdata  = v.dwd;
      #1;
      if (exp_q.size() > 0) begin
         r = exp_q.pop_front();
         if (v.rst) r = '0;
         chk("i_rvalid", 32'(bus.i_rvalid), 32'(r.iv));
         chk("d_rvalid", 32'(bus.d_rvalid), 32'(r.dv));
         chk("d_err", 32'(bus.d_err), 32'(r.er));
         if (r.iv || v.rst) chk("i_rdata", bus.i_rdata, r.id);
         if (r.dv || v.rst) chk("d_rdata", bus.d_rdata, r.dd);
      end
      chk("i_ack", 32'(bus.i_ack), 32'(v.eia));
      chk("d_ack", 32'(bus.d_ack), 32'(v.eda));
      chk("mem_read_en", 32'(bus.mem_read_en), 32'(v.ern));
      chk("mem_write_en", 32'(bus.mem_write_en), 32'(v.ewn));
      chk("mem_write_sel", 32'(bus.mem_write_sel), 32'(v.esel));
      if (v.ern || v.ewn || !(v.eia || v.eda)) chk("mem_addr", bus.mem_addr, v.eaddr);
      if (v.ewn || !(v.eia || v.eda)) chk("mem_wdata", bus.mem_wdata, v.ewd);
      exp_q.push_back('{v.riv, v.rid, v.rdv, v.rdd, v.rer});
   endtask

   initial begin
      vec_t v;
      //          rst ir ia          dr we sz sg da          dwd           eia eda ern ewn sel  eaddr        ewd           riv rid           rdv rdd           rer
      vecs[0]  = '{1, 1, 32'h100, 1, 0, 2, 0, 32'h100, 32'h0,        0, 0, 0, 0, 4'h0, 32'h0,   32'h0,        0, 32'h0,        0, 32'h0,        0};
      vecs[1]  = '{0, 1, 32'h100, 0, 0, 0, 0, 32'h0,   32'h0,        1, 0, 1, 0, 4'h0, 32'h100, 32'h0,        1, 32'h0,        0, 32'h0,        0};
      vecs[2]  = '{1, 1, 32'h100, 1, 1, 2, 0, 32'h100, 32'hFFFFFFFF, 0, 0, 0, 0, 4'h0, 32'h0,   32'h0,        0, 32'h0,        0, 32'h0,        0};
      vecs[3]  = '{0, 0, 32'h0,   0, 0, 0, 0, 32'h0,   32'h0,        0, 0, 0, 0, 4'h0, 32'h0,   32'h0,        0, 32'h0,        0, 32'h0,        0};
      vecs[4]  = '{0, 0, 32'h0,   1, 1, 2, 0, 32'h100, 32'h8C010004, 0, 1, 0, 1, 4'hF, 32'h100, 32'h8C010004, 0, 32'h0,        0, 32'h0,        0};
      vecs[5]  = '{0, 1, 32'h103, 0, 0, 0, 0, 32'h0,   32'h0,        1, 0, 1, 0, 4'h0, 32'h100, 32'h0,        1, 32'h8C010004, 0, 32'h0,        0};
      vecs[6]  = '{0, 0, 32'h0,   1, 1, 0, 0, 32'h203, 32'h123456A5, 0, 1, 0, 1, 4'h8, 32'h200, 32'hA5A5A5A5, 0, 32'h0,        0, 32'h0,        0};
      vecs[7]  = '{0, 0, 32'h0,   1, 0, 0, 1, 32'h203, 32'h0,        0, 1, 1, 0, 4'h0, 32'h200, 32'h0,        0, 32'h0,        1, 32'hFFFFFFA5, 0};
      vecs[8]  = '{0, 0, 32'h0,   1, 0, 0, 0, 32'h203, 32'h0,        0, 1, 1, 0, 4'h0, 32'h200, 32'h0,        0, 32'h0,        1, 32'h000000A5, 0};
      vecs[9]  = '{0, 0, 32'h0,   1, 1, 1, 0, 32'h206, 32'hFFFF8001, 0, 1, 0, 1, 4'hC, 32'h204, 32'h80018001, 0, 32'h0,        0, 32'h0,        0};
      vecs[10] = '{0, 0, 32'h0,   1, 0, 1, 1, 32'h206, 32'h0,        0, 1, 1, 0, 4'h0, 32'h204, 32'h0,        0, 32'h0,        1, 32'hFFFF8001, 0};
      vecs[11] = '{0, 0, 32'h0,   1, 0, 1, 0, 32'h206, 32'h0,        0, 1, 1, 0, 4'h0, 32'h204, 32'h0,        0, 32'h0,        1, 32'h00008001, 0};
      vecs[12] = '{0, 0, 32'h0,   1, 0, 0, 1, 32'h207, 32'h0,        0, 1, 1, 0, 4'h0, 32'h204, 32'h0,        0, 32'h0,        1, 32'hFFFFFF80, 0};
      vecs[13] = '{0, 0, 32'h0,   1, 0, 2, 0, 32'h202, 32'h0,        0, 1, 0, 0, 4'h0, 32'h0,   32'h0,        0, 32'h0,        0, 32'h0,        1};
      vecs[14] = '{0, 0, 32'h0,   1, 0, 3, 0, 32'h200, 32'h0,        0, 1, 0, 0, 4'h0, 32'h0,   32'h0,        0, 32'h0,        0, 32'h0,        1};
      vecs[15] = '{0, 0, 32'h0,   1, 1, 1, 0, 32'h203, 32'h1234,     0, 1, 0, 0, 4'h0, 32'h0,   32'h0,        0, 32'h0,        0, 32'h0,        1};
      vecs[16] = '{0, 0, 32'h0,   1, 1, 2, 0, 32'h101, 32'hDEADBEEF, 0, 1, 0, 0, 4'h0, 32'h0,   32'h0,        0, 32'h0,        0, 32'h0,        1};
      vecs[17] = '{0, 0, 32'h0,   1, 0, 2, 0, 32'h100, 32'h0,        0, 1, 1, 0, 4'h0, 32'h100, 32'h0,        0, 32'h0,        1, 32'h8C010004, 0};
      vecs[18] = '{0, 0, 32'h0,   1, 1, 0, 0, 32'h201, 32'h5A,       0, 1, 0, 1, 4'h2, 32'h200, 32'h5A5A5A5A, 0, 32'h0,        0, 32'h0,        0};
      vecs[19] = '{0, 0, 32'h0,   1, 0, 2, 0, 32'h200, 32'h0,        0, 1, 1, 0, 4'h0, 32'h200, 32'h0,        0, 32'h0,        1, 32'hA5005A00, 0};
      vecs[20] = '{0, 1, 32'h200, 0, 0, 0, 0, 32'h0,   32'h0,        1, 0, 1, 0, 4'h0, 32'h200, 32'h0,        1, 32'hA5005A00, 0, 32'h0,        0};
      vecs[21] = '{0, 0, 32'h0,   1, 0, 1, 1, 32'h200, 32'h0,        0, 1, 1, 0, 4'h0, 32'h200, 32'h0,        0, 32'h0,        1, 32'h00005A00, 0};
      vecs[22] = '{0, 0, 32'h0,   0, 0, 0, 0, 32'h0,   32'h0,        0, 0, 0, 0, 4'h0, 32'h0,   32'h0,        0, 32'h0,        0, 32'h0,        0};

      bus.i_req = 1'b0; bus.i_addr = 32'h0; bus.d_req = 1'b0; bus.d_we = 1'b0;
      bus.d_size = 2'b00; bus.d_signed = 1'b0; bus.d_addr = 32'h0; bus.d_wdata = 32'h0;

      for (int n = 0; n < NV; n++) step(vecs[n]);

      // Starvation: D wins 3 cycles, I drops for one cycle (counter clears), then D wins 4 more
      // and I wins on the 5th contended cycle; D resumes right after.
      for (int k = 0; k < 10; k++) begin
         v = vecs[22];
         v.ir = (k != 3); v.ia = 32'h100;
         v.dr = 1'b1; v.dsz = 2'b10; v.da = 32'h200;
         if (k == 8) begin
            v.eia = 1'b1; v.ern = 1'b1; v.eaddr = 32'h100; v.riv = 1'b1; v.rid = 32'h8C010004;
         end else begin
            v.eda = 1'b1; v.ern = 1'b1; v.eaddr = 32'h200; v.rdv = 1'b1; v.rdd = 32'hA5005A00;
         end
         step(v);
      end
      step(vecs[22]);
      step(vecs[22]);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
